// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state type, frame geometry and default timing
// parameters. Used by the receiver today and by the host-to-device
// transmitter later, so keep it free of receiver-only detail.
package ps2_pkg;

   // Frame tracking states: start bit seen in IDLE, then data, parity, stop.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam int PS2_DATA_BITS = 8;

   // Default consecutive-sample count before the filtered clock may change.
   localparam int PS2_FILTER_LEN_DEF = 8;

   // Default mid-frame idle limit: 1 ms at 50 MHz.
   localparam int PS2_TIMEOUT_CYCLES_DEF = 50000;

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose : 2-flop synchroniser, glitch filter and falling-edge detect for one PS/2 line.
// Latency : raw line change to fall_o = 2 sync cycles + FILTER_LEN cycles.
// Backpr. : none; fall_o is a single-cycle event that must be consumed when seen.
//
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset (sync flops and filter go to idle-high)
//   line_i  in  raw asynchronous line
//   fall_o  out one-cycle pulse in the cycle the filtered level commits to low
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic fall_o
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [1:0]       sync_q;
   logic             filt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             differ;
   logic             flip;

   assign differ = (sync_q[1] != filt_q);
   // The FILTER_LEN-th consecutive differing sample commits the new level.
   assign flip   = differ && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         // A matching sample restarts the run; a committed flip also restarts it,
         // so the counter never exceeds FILTER_LEN-1.
         if (!differ || flip) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (flip) begin
            filt_q <= ~filt_q;
         end
      end
   end

   // Sample event is flagged in the cycle the drop is decided, so the data line
   // (same synchroniser depth) is read alongside it.
   assign fall_o = flip && filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// Purpose : PS/2 device-to-host deserialiser: 11-bit frames in, checked bytes out.
// Latency : strobe one cycle after the stop-bit sample event (event = raw edge + 2 + FILTER_LEN).
// Backpr. : none; every received_data_en / frame_error strobe must be taken when asserted.
//
// Ports:
//   clk, rst           50 MHz clock, synchronous active-high reset
//   rx_en              receive enable; low forces IDLE and drops any partial frame silently
//   ps2_clk, ps2_data  raw asynchronous PS/2 lines
//   received_data      last good byte, held until the next good frame
//   received_data_en   one-cycle strobe, received_data newly valid
//   frame_error        one-cycle strobe, frame rejected (parity/stop, or timeout)
// Build option: define PS2_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_en,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   output logic [PS2_DATA_BITS-1:0] received_data,
   output logic                     received_data_en,
   output logic                     frame_error
);

   localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

   logic [1:0]               data_sync_q;
   logic                     data_s;
   logic                     evt;
   ps2_state_e               state_q;
   logic [2:0]               bit_cnt_q;
   logic [PS2_DATA_BITS-1:0] shift_q;
   logic                     parity_q;
   logic [PS2_DATA_BITS-1:0] rdata_q;
   logic                     rdata_en_q;
   logic                     frame_err_q;
   logic                     tmo_hit;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk    (clk),
      .rst    (rst),
      .line_i (ps2_clk),
      .fall_o (evt)
   );

   // Data is only synchronised: it is stable around the clock falling edge,
   // and the filter delay on the clock keeps the sample well inside the bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_sync_q <= 2'b11;
      end else begin
         data_sync_q <= {data_sync_q[0], ps2_data};
      end
   end
   assign data_s = data_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q;

   // tmo_q holds (cycles since last event - 1), so the hit lands exactly
   // TIMEOUT_CYCLES cycles after the event that last cleared it.
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst || !rx_en || evt || tmo_hit || (state_q == ST_IDLE)) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   logic unused_tmo_cfg;

   assign tmo_hit        = 1'b0;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         rdata_q     <= '0;
         rdata_en_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rdata_en_q  <= 1'b0;
         frame_err_q <= 1'b0;
         if (!rx_en) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
         end else if (evt) begin
            // A sample event outranks a simultaneous timeout.
            case (state_q)
               ST_IDLE: begin
                  // A high "start bit" is line noise: ignore without complaint.
                  if (!data_s) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shift_q <= {data_s, shift_q[PS2_DATA_BITS-1:1]};
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= ST_PARITY;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
               ST_PARITY: begin
                  parity_q <= data_s;
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  // Odd parity: data bits plus parity bit must hold an odd count of ones.
                  if (data_s && ((^shift_q) ^ parity_q)) begin
                     rdata_q    <= shift_q;
                     rdata_en_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end else if (tmo_hit) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
         end
      end
   end

   assign received_data    = rdata_q;
   assign received_data_en = rdata_en_q;
   assign frame_error      = frame_err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

   localparam int FL  = 8;
   localparam int TMO = 1000;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       rx_en    = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       frame_error;

   ps2_receiver #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_en            (rx_en),
      .ps2_clk          (ps2_clk),
      .ps2_data         (ps2_data),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .frame_error      (frame_error)
   );

   always #10 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_fall_cyc = 0;
   int         last_err_cyc = 0;
   int         err_seen = 0;
   logic [7:0] got_q[$];
   logic [7:0] model_rd = 8'h00;
   logic       prev_en = 1'b0;
   logic       prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe collector: records every delivered byte and every rejection, and
   // checks strobes are exclusive and exactly one cycle wide.
   always @(negedge clk) begin
      if (received_data_en) got_q.push_back(received_data);
      if (frame_error) begin
         err_seen++;
         last_err_cyc = cyc;
      end
      if (received_data_en || frame_error) begin
         checks++;
         if ((received_data_en && frame_error) || (received_data_en && prev_en) ||
             (frame_error && prev_err)) begin
            errors++;
            $display("FAIL strobe_shape en=%0b err=%0b prev_en=%0b prev_err=%0b (need single-cycle, exclusive)",
                     received_data_en, frame_error, prev_en, prev_err);
         end
      end
      prev_en  = received_data_en;
      prev_err = frame_error;
   end

   // Reference: odd parity bit for a byte, from the ones count.
   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic frame_good(input logic [7:0] d, input logic p, input logic s);
      int ones;
      ones = $countones(d) + int'(p);
      return s && (ones % 2 == 1);
   endfunction

   // Drive the first n bits of a frame (start, data LSB-first, parity, stop)
   // the way a device does: data changes while the clock is high.
   task automatic send_bits(input logic [7:0] d, input logic p, input logic s, input int n);
      logic [10:0] fr;
      int          hp;
      fr = {s, p, d, 1'b0};
      hp = $urandom_range(40, 20);
      for (int i = 0; i < n; i++) begin
         ps2_data = fr[i];
         repeat (hp) @(negedge clk);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (hp) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bits(d, p, s, 11);
      repeat (10) @(negedge clk);
      if (frame_good(d, p, s)) model_rd = d;
   endtask

   task automatic clear_obs();
      got_q.delete();
      err_seen = 0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      rx_en = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (received_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got=%h want=00", received_data);
      end
      checks++;
      if (received_data_en !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes en=%b err=%b want 0 0", received_data_en, frame_error);
      end
   endtask

   task automatic test_single();
      clear_obs();
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++;
      if (got_q.size() != 1 || err_seen != 0) begin
         errors++;
         $display("FAIL single_count strobes=%0d errs=%0d want 1 0", got_q.size(), err_seen);
      end else if (got_q[0] !== 8'h1C) begin
         errors++;
         $display("FAIL single_data got=%h want=1c", got_q[0]);
      end
   endtask

   task automatic test_two();
      clear_obs();
      send_frame(8'h1C, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b1);
      repeat (50) @(negedge clk);
      checks++;
      if (got_q.size() != 2) begin
         errors++;
         $display("FAIL two_count strobes=%0d want 2", got_q.size());
      end else if (got_q[0] !== 8'h1C || got_q[1] !== 8'hF0) begin
         errors++;
         $display("FAIL two_data got=%h,%h want 1c,f0", got_q[0], got_q[1]);
      end
      checks++;
      if (received_data !== 8'hF0) begin
         errors++;
         $display("FAIL two_hold got=%h want=f0", received_data);
      end
   endtask

   task automatic test_bad_frames();
      for (int k = 0; k < 2; k++) begin
         clear_obs();
         if (k == 0) send_frame(8'h1C, 1'b1, 1'b1);
         else        send_frame(8'h1C, 1'b0, 1'b0);
         checks++;
         if (err_seen != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL bad_frame%0d errs=%0d strobes=%0d want 1 0", k, err_seen, got_q.size());
         end
         checks++;
         if (received_data !== model_rd) begin
            errors++;
            $display("FAIL bad_frame%0d_hold got=%h want=%h", k, received_data, model_rd);
         end
      end
   endtask

   task automatic test_glitch();
      clear_obs();
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (got_q.size() != 0 || err_seen != 0) begin
         errors++;
         $display("FAIL glitch_quiet strobes=%0d errs=%0d want 0 0", got_q.size(), err_seen);
      end
      send_frame(8'hAA, odd_par(8'hAA), 1'b1);
      checks++;
      if (got_q.size() != 1 || received_data !== 8'hAA) begin
         errors++;
         $display("FAIL glitch_next strobes=%0d data=%h want 1 aa", got_q.size(), received_data);
      end
   endtask

   task automatic test_stall();
      clear_obs();
      send_bits(8'h77, 1'b0, 1'b1, 6);
      repeat (TMO + 200) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
      checks++;
      if (err_seen != 1) begin
         errors++;
         $display("FAIL timeout_count errs=%0d want 1", err_seen);
      end else if (last_err_cyc - last_fall_cyc < TMO || last_err_cyc - last_fall_cyc > TMO + 30) begin
         errors++;
         $display("FAIL timeout_delay got=%0d want %0d..%0d", last_err_cyc - last_fall_cyc, TMO, TMO + 30);
      end
`else
      checks++;
      if (err_seen != 0) begin
         errors++;
         $display("FAIL stall_wait errs=%0d want 0", err_seen);
      end
      @(negedge clk);
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      rx_en = 1'b1;
`endif
      clear_obs();
      send_frame(8'h5A, odd_par(8'h5A), 1'b1);
      checks++;
      if (got_q.size() != 1 || received_data !== 8'h5A || err_seen != 0) begin
         errors++;
         $display("FAIL stall_next strobes=%0d data=%h errs=%0d want 1 5a 0", got_q.size(), received_data, err_seen);
      end
   endtask

   task automatic test_rst_abort();
      clear_obs();
      send_bits(8'h33, 1'b1, 1'b1, 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (received_data !== 8'h00 || received_data_en !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort_outputs data=%h en=%b err=%b want 00 0 0", received_data, received_data_en, frame_error);
      end
      rst = 1'b0;
      model_rd = 8'h00;
      send_frame(8'h12, odd_par(8'h12), 1'b1);
      checks++;
      if (got_q.size() != 1 || received_data !== 8'h12 || err_seen != 0) begin
         errors++;
         $display("FAIL rst_abort_next strobes=%0d data=%h errs=%0d want 1 12 0", got_q.size(), received_data, err_seen);
      end
   endtask

   task automatic test_rx_en_abort();
      clear_obs();
      send_bits(8'hC3, 1'b1, 1'b1, 4);
      @(negedge clk);
      rx_en = 1'b0;
      repeat (20) @(negedge clk);
      rx_en = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (err_seen != 0 || got_q.size() != 0) begin
         errors++;
         $display("FAIL rx_en_abort errs=%0d strobes=%0d want 0 0", err_seen, got_q.size());
      end
      send_frame(8'h12, odd_par(8'h12), 1'b1);
      checks++;
      if (got_q.size() != 1 || received_data !== 8'h12) begin
         errors++;
         $display("FAIL rx_en_next strobes=%0d data=%h want 1 12", got_q.size(), received_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      int         exp_err;
      logic [7:0] d;
      logic       p;
      logic       s;
      int         kind;
      clear_obs();
      exp_err = 0;
      for (int i = 0; i < 20; i++) begin
         d    = 8'($urandom);
         kind = $urandom_range(5, 0);
         p    = odd_par(d);
         s    = 1'b1;
         if (kind == 0) p = ~p;
         if (kind == 1) s = 1'b0;
         if (frame_good(d, p, s)) exp_q.push_back(d);
         else                     exp_err++;
         send_frame(d, p, s);
      end
      checks++;
      if (got_q.size() != exp_q.size() || err_seen != exp_err) begin
         errors++;
         $display("FAIL b2b_count strobes=%0d errs=%0d want %0d %0d", got_q.size(), err_seen, exp_q.size(), exp_err);
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL b2b_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (received_data !== model_rd) begin
         errors++;
         $display("FAIL b2b_hold got=%h want=%h", received_data, model_rd);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two();
      test_bad_frames();
      test_glitch();
      test_stall();
      test_rst_abort();
      test_rx_en_abort();
      test_back_to_back();
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
